// File: rtl/mc_control_unit.sv
// Main controller of the multi-cycle MIPS core: Moore FSM sequencing fetch/decode/
// execute/memory/writeback, plus ALU control decode from state and funct.
module mc_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_reg, state_next;
    logic       pc_write;
    logic       branch;
    logic [2:0] funct_alu;
    logic       funct_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = S_FETCH;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        case (state_reg)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
                if (funct_ok) begin
                    state_next = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign pc_en = pc_write | (branch & zero_flag);
    assign state = state_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected state/outputs are queued
// per instruction and compared cycle by cycle on the falling clock edge.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_flag;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_en;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;

    mc_control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero_flag   (zero_flag),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .alu_control (alu_control),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] obs_outs;
    assign obs_outs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                       alu_src_b, pc_src, pc_en, alu_control, illegal};

    function automatic logic [15:0] mk(input logic io, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic pen,
                                       input logic [2:0] alu, input logic ill);
        return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, pen, alu, ill};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [15:0] v);
        sb_q.push_back({st, v});
    endtask

    // FETCH and DECODE open every instruction
    task automatic push_fd(input logic ill);
        push(4'd0, mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0));
        push(4'd1, mk(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,ill));
    endtask

    // Entered at a falling edge with the DUT in FETCH; drains the queue one cycle per entry
    task automatic run_txn(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic zf);
        int   cyc;
        int   errs0;
        exp_t e;
        cyc   = 0;
        errs0 = n_checks - n_pass;
        opcode    = op;
        funct     = fn;
        zero_flag = zf;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            #1;
            check_value($sformatf("%s c%0d state", name, cyc), {28'd0, state}, {28'd0, e.st});
            check_value($sformatf("%s c%0d outs", name, cyc), {16'd0, obs_outs}, {16'd0, e.outs});
            cyc++;
            @(negedge clk);
        end
        $display("txn %-10s op=%b funct=%b zf=%0d cycles=%0d errors=%0d",
                 name, op, fn, zf, cyc, (n_checks - n_pass) - errs0);
    endtask

    logic [5:0] r_fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] r_alu [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b100011;
        funct     = 6'b000000;
        zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_value("reset state", {28'd0, state}, 32'd0);
        check_value("reset outs", {16'd0, obs_outs},
                    {16'd0, mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0)});
        rst_n = 1'b1;

        // lw, with zero_flag high to show it cannot leak into pc_en outside BRANCH
        push_fd(0);
        push(4'd2, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        push(4'd3, mk(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        push(4'd4, mk(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0));
        run_txn("lw", 6'b100011, 6'b000000, 1'b1);

        for (int i = 0; i < 5; i++) begin
            push_fd(0);
            push(4'd6, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,r_alu[i],0));
            push(4'd7, mk(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0));
            run_txn($sformatf("rtype%0d", i), 6'b000000, r_fn[i], 1'b0);
        end

        for (int z = 1; z >= 0; z--) begin
            push_fd(0);
            push(4'd8, mk(0,0,0,0,0,0,1,2'b00,2'b01,z[0],3'b110,0));
            run_txn($sformatf("beq_z%0d", z), 6'b000100, 6'b101010, z[0]);
        end

        push_fd(0);
        push(4'd2, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        push(4'd5, mk(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0));
        run_txn("sw", 6'b101011, 6'b000000, 1'b1);

        push_fd(0);
        push(4'd9,  mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        push(4'd10, mk(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0));
        run_txn("addi", 6'b001000, 6'b100010, 1'b1);

        push_fd(0);
        push(4'd11, mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0));
        run_txn("j", 6'b000010, 6'b000000, 1'b0);

        push_fd(1);
        run_txn("ill_op", 6'b111111, 6'b100000, 1'b0);

        push_fd(0);
        push(4'd6, mk(0,0,0,0,0,0,1,2'b00,2'b00,0,3'b010,1));
        run_txn("ill_fn", 6'b000000, 6'b000000, 1'b0);

        // Asynchronous reset while in MEMWR, between clock edges
        push_fd(0);
        push(4'd2, mk(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0));
        run_txn("sw_rst", 6'b101011, 6'b000000, 1'b0);
        #1;
        check_value("memwr state", {28'd0, state}, 32'd5);
        check_value("memwr mem_write", {31'd0, mem_write}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async rst state", {28'd0, state}, 32'd0);
        check_value("async rst mem_write", {31'd0, mem_write}, 32'd0);
        check_value("async rst outs", {16'd0, obs_outs},
                    {16'd0, mk(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0)});
        @(negedge clk);
        rst_n = 1'b1;

        push_fd(0);
        push(4'd11, mk(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0));
        run_txn("j_after", 6'b000010, 6'b000000, 1'b0);
        #1;
        check_value("final state", {28'd0, state}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Main controller of the multi-cycle MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, driving every datapath mux and enable. It also owns ALU decoding: it drives the 3-bit `alu_control` input of the ALU directly, from the current state and the instruction `funct` field. It consumes the ALU `zero_flag` to resolve `beq`.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: `instr[31:26]` from the instruction register.
- `funct` in 6: `instr[5:0]` from the instruction register.
- `zero_flag` in 1: ALU zero output, evaluated in the BRANCH state.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_write` out 1: memory write enable.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: register-file write address select (0 = rt, 1 = rd).
- `mem_to_reg` out 1: register-file write data select (0 = ALUOut, 1 = Data register).
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU operand A select (0 = PC, 1 = A register).
- `alu_src_b` out 2: ALU operand B select (00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
- `pc_src` out 2: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `pc_en` out 1: PC load. Equals `pc_write | (branch & zero_flag)`.
- `alu_control` out 3: ALU operation code.
- `illegal` out 1: one-cycle pulse when the opcode or funct is unsupported.
- `state` out 4: current state, for debug and verification.

## Operation
- ALU codes: ADD=010, SUB=110, AND=000, OR=001, SLT=111.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Opcodes: R-type=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Funct codes: add=100000, sub=100010, and=100100, or=100101, slt=101010.

Outputs per state. Any output not listed is 0, and `alu_control` defaults to ADD:
- FETCH: `ir_write`=1, `pc_write`=1, `alu_src_b`=01, ADD. Next state is DECODE.
- DECODE: `alu_src_b`=11, ADD (precomputes the branch target). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode → FETCH, with `illegal`=1 in DECODE.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1. Next state is MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1. Next state is FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Next state is FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00. `alu_control` is decoded from `funct`.
  - Unknown funct: `alu_control`=ADD, `illegal`=1, next state FETCH (no writeback).
  - Otherwise next state is ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1. Next state is FETCH.
- BRANCH: `alu_src_a`=1, SUB, `pc_src`=01, `branch`=1. Next state is FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, ADD. Next state is ADDIWB.
- ADDIWB: `reg_write`=1 (`reg_dst`=0). Next state is FETCH.
- JUMP: `pc_src`=10, `pc_write`=1. Next state is FETCH.

Structural rules:
- `pc_write` and `branch` are internal signals; only `pc_en` is exported.
- The next-state logic has a default branch to FETCH, so an unreachable encoding (12–15) recovers in one cycle.
- All outputs are combinational from `state`. `alu_control` and `illegal` additionally depend on `opcode`/`funct`; `pc_en` additionally depends on `zero_flag`.
- `opcode`/`funct` are sampled only in DECODE, MEMADR and EXECUTE. The instruction register is stable after FETCH.

## Timing
Reset:
- Asserting `rst_n`=0 forces `state`=FETCH immediately (asynchronously).
- Outputs during reset are the FETCH decode: `ir_write`=1, `pc_en`=1, `alu_src_b`=01, `alu_control`=010, all other outputs 0. Datapath registers are held in reset by the same `rst_n`, so these enables have no effect.
- Deassertion: the first rising edge with `rst_n`=1 performs the first real FETCH.
- Reset mid-instruction abandons the instruction. No partial writeback occurs after reset, because `reg_write` and `mem_write` are 0 in FETCH.

Cycles per instruction, FETCH to FETCH inclusive:
- lw: 5
- sw, R-type, addi: 4
- beq, j: 3
- illegal opcode: 2
- illegal funct: 3

Branch resolution:
- `pc_en` in BRANCH follows `zero_flag` combinationally within the same cycle.
- The PC updates at the edge that ends BRANCH.

## Test plan
- Reset then lw (opcode 100011): hold `rst_n`=0 and check FETCH outputs and `state`=0. Release; `state` must step 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in state 4; `iord`=1 in state 3.
- R-type sweep over funct 100000/100010/100100/100101/101010: `alu_control` in EXECUTE must be 010/110/000/001/111 respectively. `reg_dst`=1 and `reg_write`=1 in ALUWB; 4 cycles each.
- beq (000100): with `zero_flag`=1, `pc_en`=1 and `pc_src`=01 in BRANCH. With `zero_flag`=0, `pc_en`=0. `alu_control`=110 in both cases; 3 cycles.
- sw, addi, j: sw gives `mem_write`=1 only in state 5. addi gives `alu_src_b`=10 in state 9 and `reg_write`=1 with `reg_dst`=0 in state 10. j gives `pc_src`=10 and `pc_en`=1 in state 11.
- Illegal cases:
  - opcode 111111 → `illegal` pulses for one cycle in DECODE, then FETCH.
  - R-type with funct 000000 → `illegal`=1 in EXECUTE, `alu_control`=010, no `reg_write`, back to FETCH.
- Assert `rst_n`=0 asynchronously between edges while in MEMWR: `state`=0 and `mem_write`=0 before the next clock edge.
